// File: rtl/memwb.sv
// memwb: memory-access / writeback stage downstream of execute.
// Non-memory results are written back the cycle after accept. Memory ops
// run one bus transaction (req held until ack), then write back on a load.
// The optional bus-ack timeout is enabled by defining MEMWB_BUS_TIMEOUT_EN.
module memwb #(
  parameter int RW      = 16,
  parameter int REGNO   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_submit,
  output logic             o_ready,
  input  logic [RW-1:0]    i_data,
  input  logic [RW-1:0]    i_addr,
  input  logic [REGNO-1:0] i_reg_ie,
  input  logic             i_mem_access,
  input  logic             i_mem_we,
  input  logic             i_mem_width,
  output logic [REGNO-1:0] o_reg_ie,
  output logic [RW-1:0]    o_reg_data,
  output logic             o_mem_req,
  output logic             o_mem_we,
  output logic [RW-1:0]    o_mem_addr,
  output logic [RW-1:0]    o_mem_data,
  output logic [1:0]       o_mem_sel,
  input  logic             i_mem_ack,
  input  logic [RW-1:0]    i_mem_data,
  input  logic             i_mem_err,
  output logic             o_mem_exception
);

  typedef enum logic {IDLE, BUSY} state_t;

  // The timeout counter is 8 bits wide, so TIMEOUT must fit in it.
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("memwb: TIMEOUT must be within 1..255");
  end

  state_t           state_q;
  logic [REGNO-1:0] reg_ie_q;
  logic [RW-1:0]    reg_data_q;
  logic             mem_req_q, mem_we_q, exc_q;
  logic [RW-1:0]    mem_addr_q, mem_data_q;
  logic [1:0]       mem_sel_q;
  // Per-transaction context needed to form the writeback on ack.
  logic [REGNO-1:0] lat_ie_q;
  logic             lat_we_q, lat_width_q, lat_a0_q;
`ifdef MEMWB_BUS_TIMEOUT_EN
  logic [7:0]       cnt_q;
`endif

  // Load result: full word, or the addressed byte zero-extended.
  logic [RW-1:0] load_data_d;
  // Select the load result from the bus read data and latched address bit.
  always_comb begin
    load_data_d = i_mem_data;
    if (lat_width_q)
      load_data_d = RW'(lat_a0_q ? i_mem_data[15:8] : i_mem_data[7:0]);
  end

  assign o_ready = (state_q == IDLE);

  // Stage FSM with registered bus and writeback outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      reg_ie_q    <= '0;
      reg_data_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      mem_sel_q   <= 2'b00;
      exc_q       <= 1'b0;
      lat_ie_q    <= '0;
      lat_we_q    <= 1'b0;
      lat_width_q <= 1'b0;
      lat_a0_q    <= 1'b0;
`ifdef MEMWB_BUS_TIMEOUT_EN
      cnt_q       <= 8'd0;
`endif
    end else begin
      // Write-enable and exception are single-cycle pulses.
      reg_ie_q <= '0;
      exc_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_submit) begin
            if (!i_mem_access) begin
              reg_ie_q   <= i_reg_ie;
              reg_data_q <= i_data;
            end else begin
              state_q     <= BUSY;
              lat_ie_q    <= i_reg_ie;
              lat_we_q    <= i_mem_we;
              lat_width_q <= i_mem_width;
              lat_a0_q    <= i_addr[0];
              mem_req_q   <= 1'b1;
              mem_we_q    <= i_mem_we;
`ifdef MEMWB_BUS_TIMEOUT_EN
              cnt_q       <= 8'd0;
`endif
              if (i_mem_width) begin
                mem_addr_q <= {1'b0, i_addr[RW-1:1]};
                mem_sel_q  <= i_addr[0] ? 2'b10 : 2'b01;
                mem_data_q <= RW'({i_data[7:0], i_data[7:0]});
              end else begin
                mem_addr_q <= i_addr;
                mem_sel_q  <= 2'b11;
                mem_data_q <= i_data;
              end
            end
          end
        end
        BUSY: begin
          if (i_mem_ack) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            if (i_mem_err) begin
              exc_q <= 1'b1;
            end else if (!lat_we_q) begin
              reg_ie_q   <= lat_ie_q;
              reg_data_q <= load_data_d;
            end
          end
`ifdef MEMWB_BUS_TIMEOUT_EN
          // Ack has priority; otherwise give up after TIMEOUT waiting cycles.
          else if (cnt_q == 8'(TIMEOUT - 1)) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            exc_q     <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
`endif
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_reg_ie        = reg_ie_q;
  assign o_reg_data      = reg_data_q;
  assign o_mem_req       = mem_req_q;
  assign o_mem_we        = mem_we_q;
  assign o_mem_addr      = mem_addr_q;
  assign o_mem_data      = mem_data_q;
  assign o_mem_sel       = mem_sel_q;
  assign o_mem_exception = exc_q;

endmodule

// File: tb/tb_memwb.sv
// Testbench for memwb: directed vector table, randomized ops against a
// transaction-level model, and hand-written reset/timeout sequences.
module tb_memwb;
  localparam int RW = 16, REGNO = 8, TO = 4;

  logic             i_clk = 1'b0, i_rst = 1'b1;
  logic             i_submit = 1'b0, o_ready;
  logic [RW-1:0]    i_data = '0, i_addr = '0;
  logic [REGNO-1:0] i_reg_ie = '0;
  logic             i_mem_access = 1'b0, i_mem_we = 1'b0, i_mem_width = 1'b0;
  logic [REGNO-1:0] o_reg_ie;
  logic [RW-1:0]    o_reg_data, o_mem_addr, o_mem_data;
  logic             o_mem_req, o_mem_we, o_mem_exception;
  logic [1:0]       o_mem_sel;
  logic             i_mem_ack = 1'b0, i_mem_err = 1'b0;
  logic [RW-1:0]    i_mem_data = '0;

  memwb #(.RW(RW), .REGNO(REGNO), .TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_submit(i_submit), .o_ready(o_ready),
    .i_data(i_data), .i_addr(i_addr), .i_reg_ie(i_reg_ie),
    .i_mem_access(i_mem_access), .i_mem_we(i_mem_we), .i_mem_width(i_mem_width),
    .o_reg_ie(o_reg_ie), .o_reg_data(o_reg_data), .o_mem_req(o_mem_req),
    .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data),
    .o_mem_sel(o_mem_sel), .i_mem_ack(i_mem_ack), .i_mem_data(i_mem_data),
    .i_mem_err(i_mem_err), .o_mem_exception(o_mem_exception));

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic mem, we, width, err;
    logic [15:0] addr, data, rdata;
    logic [7:0] ie;
    int wait_cyc;
    logic [15:0] x_addr, x_wdata, x_rdata;
    logic [1:0] x_sel;
    logic [7:0] x_ie;
    logic x_exc;
  } vec_t;

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h required %0h", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge i_clk); #1;
  endtask

  // Reference model: expected bus fields and writeback from the op's meaning.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    int a0 = v.addr % 2;
    r.x_addr  = v.width ? 16'(v.addr / 2) : v.addr;
    r.x_sel   = v.width ? (a0 ? 2'd2 : 2'd1) : 2'd3;
    r.x_wdata = v.width ? 16'((v.data % 256) * 257) : v.data;
    if (!v.mem) begin
      r.x_ie = v.ie; r.x_rdata = v.data; r.x_exc = 1'b0;
    end else begin
      r.x_exc   = v.err;
      r.x_ie    = (v.err || v.we) ? 8'h00 : v.ie;
      r.x_rdata = v.width ? 16'((v.rdata >> (8 * a0)) % 256) : v.rdata;
    end
    return r;
  endfunction

  // Apply one op from IDLE and check every observable step.
  task automatic run_op(input vec_t v);
    i_data = v.data; i_addr = v.addr; i_reg_ie = v.ie;
    i_mem_access = v.mem; i_mem_we = v.we; i_mem_width = v.width;
    i_submit = 1'b1;
    chk("ready_at_submit", o_ready, 1);
    tick();
    i_submit = 1'b0;
    if (!v.mem) begin
      chk("alu_reg_ie", o_reg_ie, v.x_ie);
      chk("alu_reg_data", o_reg_data, v.x_rdata);
      return;
    end
    chk("req_rise", o_mem_req, 1);
    chk("busy_ready", o_ready, 0);
    chk("mem_we", o_mem_we, v.we);
    chk("mem_addr", o_mem_addr, v.x_addr);
    chk("mem_sel", o_mem_sel, v.x_sel);
    chk("mem_wdata", o_mem_data, v.x_wdata);
    chk("busy_reg_ie", o_reg_ie, 0);
    for (int w = 0; w < v.wait_cyc; w++) begin
      i_submit = 1'b1;   // must be ignored while busy
      tick();
      chk("req_held", o_mem_req, 1);
      chk("addr_held", o_mem_addr, v.x_addr);
      chk("busy_wait_ready", o_ready, 0);
    end
    i_submit = 1'b0;
    i_mem_ack = 1'b1; i_mem_data = v.rdata; i_mem_err = v.err;
    tick();
    i_mem_ack = 1'b0; i_mem_err = 1'b0;
    chk("req_drop", o_mem_req, 0);
    chk("ready_after_ack", o_ready, 1);
    chk("wb_reg_ie", o_reg_ie, v.x_ie);
    if (v.x_ie != 0) chk("wb_reg_data", o_reg_data, v.x_rdata);
    chk("exc_pulse", o_mem_exception, v.x_exc);
    tick();
    chk("exc_clear", o_mem_exception, 0);
    chk("reg_ie_clear", o_reg_ie, 0);
  endtask

  vec_t tbl[4];
  vec_t rv;

  initial begin
    // Directed vectors (expected values written out by hand).
    //           mem we wd err addr     data     rdata    ie    wt  x_addr   x_wdata  x_rdata  sel   x_ie  exc
    tbl[0] = '{1'b1,1'b0,1'b0,1'b0,16'h1234,16'h0000,16'hBEEF,8'h10,3, 16'h1234,16'h0000,16'hBEEF,2'b11,8'h10,1'b0};
    tbl[1] = '{1'b1,1'b0,1'b1,1'b0,16'h0201,16'h0000,16'hA55A,8'h20,1, 16'h0100,16'h0000,16'h00A5,2'b10,8'h20,1'b0};
    tbl[2] = '{1'b1,1'b1,1'b1,1'b0,16'h0200,16'h00C3,16'h0000,8'h40,0, 16'h0100,16'hC3C3,16'h0000,2'b01,8'h00,1'b0};
    tbl[3] = '{1'b1,1'b0,1'b0,1'b1,16'h0010,16'h5555,16'h1111,8'h80,2, 16'h0010,16'h5555,16'h1111,2'b11,8'h00,1'b1};

    tick(); tick();
    i_rst = 1'b0;
    chk("rst_ready", o_ready, 1);
    chk("rst_req", o_mem_req, 0);
    chk("rst_reg_ie", o_reg_ie, 0);
    chk("rst_reg_data", o_reg_data, 0);
    chk("rst_addr", o_mem_addr, 0);
    chk("rst_sel", o_mem_sel, 0);
    chk("rst_exc", o_mem_exception, 0);

    // Back-to-back non-memory ops: one per cycle.
    for (int k = 0; k < 3; k++) begin
      i_submit = 1'b1; i_mem_access = 1'b0;
      i_reg_ie = 8'(2 << k); i_data = 16'(k + 1);
      tick();
      chk("b2b_reg_ie", o_reg_ie, 2 << k);
      chk("b2b_reg_data", o_reg_data, k + 1);
      chk("b2b_ready", o_ready, 1);
    end
    i_submit = 1'b0;
    tick();
    chk("b2b_idle_ie", o_reg_ie, 0);

    for (int k = 0; k < 4; k++) run_op(tbl[k]);

    // Reset while waiting for ack, then a stray ack in IDLE.
    i_submit = 1'b1; i_mem_access = 1'b1; i_mem_we = 1'b0; i_mem_width = 1'b0;
    i_addr = 16'h0042; i_reg_ie = 8'h04;
    tick(); i_submit = 1'b0;
    tick();
    chk("pre_rst_req", o_mem_req, 1);
    i_rst = 1'b1; tick(); i_rst = 1'b0;
    chk("rst_busy_req", o_mem_req, 0);
    chk("rst_busy_ready", o_ready, 1);
    i_mem_ack = 1'b1; i_mem_data = 16'hDEAD; tick(); i_mem_ack = 1'b0;
    chk("late_ack_ie", o_reg_ie, 0);
    chk("late_ack_exc", o_mem_exception, 0);
    chk("late_ack_req", o_mem_req, 0);
    chk("late_ack_ready", o_ready, 1);

    // No ack: timeout build gives up after TO busy cycles, else waits.
    begin
      int req_cycles = 0;
      bit saw_exc = 1'b0;
      i_submit = 1'b1; i_reg_ie = 8'h08;
      tick(); i_submit = 1'b0;
      for (int c = 0; c < 20 && o_mem_req; c++) begin
        req_cycles++;
        tick();
        if (o_mem_exception) saw_exc = 1'b1;
      end
`ifdef MEMWB_BUS_TIMEOUT_EN
      chk("timeout_cycles", req_cycles, TO);
      chk("timeout_exc", saw_exc, 1);
      chk("timeout_ie", o_reg_ie, 0);
      tick();
      chk("timeout_exc_clear", o_mem_exception, 0);
`else
      chk("no_timeout_req", o_mem_req, 1);
      chk("no_timeout_exc", saw_exc, 0);
      i_mem_ack = 1'b1; i_mem_data = 16'h7777; tick(); i_mem_ack = 1'b0;
      chk("late_wb_ie", o_reg_ie, 8'h08);
      chk("late_wb_data", o_reg_data, 16'h7777);
      tick();
`endif
    end

    // Randomized ops against the model.
    for (int n = 0; n < 60; n++) begin
      rv = '{default: '0};
      rv.mem = 1'($urandom_range(0, 2) != 0);
      rv.we = 1'($urandom); rv.width = 1'($urandom);
      rv.err = 1'($urandom_range(0, 5) == 0);
      rv.addr = 16'($urandom); rv.data = 16'($urandom); rv.rdata = 16'($urandom);
      rv.ie = 8'(1 << $urandom_range(0, 7));
      rv.wait_cyc = $urandom_range(0, TO - 2);
      run_op(model(rv));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/memwb.md
Name: memwb

Overview:
- Memory-access / writeback stage; sits directly downstream of the execute stage.
- Consumes execute's registered result bundle (data, address, register write-enable, memory control).
- Performs at most one data-bus transaction per instruction.
- Drives the register-file write port (o_reg_ie/o_reg_data) and the memory-exception pulse back to execute.

Parameters:
- RW, 16, datapath / address width.
- REGNO, 8, number of architectural registers (one-hot write-enable width).
- TIMEOUT, 255, bus-ack timeout in cycles (used only with the optional feature); 8-bit counter.

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset.
- i_submit  in  1  execute presents a valid instruction this cycle.
- o_ready  out  1  stage can accept; wired to execute's next-ready input.
- i_data  in  RW  ALU result, or store data for memory ops.
- i_addr  in  RW  memory address (byte address when i_mem_width=1).
- i_reg_ie  in  REGNO  one-hot destination register (0 = none).
- i_mem_access  in  1  instruction accesses memory.
- i_mem_we  in  1  1 = store, 0 = load.
- i_mem_width  in  1  0 = 16-bit word, 1 = byte.
- o_reg_ie  out  REGNO  register-file write-enable (one-cycle pulse).
- o_reg_data  out  RW  register-file write data.
- o_mem_req  out  1  bus request, held until ack.
- o_mem_we  out  1  bus write.
- o_mem_addr  out  RW  bus word address.
- o_mem_data  out  RW  bus write data.
- o_mem_sel  out  2  byte lane select ([0] = low byte).
- i_mem_ack  in  1  bus transfer complete.
- i_mem_data  in  RW  bus read data, valid with ack.
- i_mem_err  in  1  bus error, qualified by ack.
- o_mem_exception  out  1  one-cycle exception pulse to execute.

Behaviour:
- Reset is decided as: i_rst is synchronous, active-high; clock is i_clk.
- Reset values: state IDLE, o_reg_ie=0, o_reg_data=0, o_mem_req=0, o_mem_we=0, o_mem_addr=0, o_mem_data=0, o_mem_sel=0, o_mem_exception=0.
- Ready: o_ready = (state==IDLE), combinational from state. Accept = i_submit & o_ready.
- FSM has two states, IDLE and BUSY.
- Non-memory instruction accepted in IDLE:
  - Next cycle: o_reg_ie=i_reg_ie, o_reg_data=i_data.
  - Stays in IDLE, so back-to-back accepts give 1 instruction/cycle.
- Memory instruction accepted in IDLE:
  - Latch i_reg_ie, i_mem_we, i_mem_width, i_addr[0]; go to BUSY.
  - Next cycle, o_mem_req=1 with address, data and select registered:
    - Word: o_mem_addr=i_addr, o_mem_sel=2'b11, o_mem_data=i_data.
    - Byte: o_mem_addr={1'b0,i_addr[RW-1:1]}, o_mem_sel = i_addr[0] ? 2'b10 : 2'b01, o_mem_data={i_data[7:0],i_data[7:0]}.
- In BUSY, bus outputs are held stable until i_mem_ack. On the ack cycle, o_mem_req drops next cycle and state returns to IDLE.
  - Load, no error: next cycle o_reg_ie=latched ie, o_reg_data = word ? i_mem_data : {8'h00, selected byte}. The high byte is selected when latched addr[0]=1.
  - Store: no register write; o_reg_ie=0.
  - i_mem_err with ack: no register write; o_mem_exception=1 for exactly one cycle.
- o_reg_ie is 0 in every cycle not listed above. o_reg_data holds its last value.
- Minimum memory-op latency is accept to writeback = 2 cycles + bus wait. o_ready returns high the cycle after ack.
- i_submit while BUSY is ignored (o_ready=0); execute holds its bundle.
- Ack arriving in the same cycle o_mem_req first rises is valid.
- Reset during BUSY:
  - Aborts the transaction and drops o_mem_req next cycle.
  - No writeback, no exception.
  - A late ack arriving in IDLE is ignored.

Optional Feature:
- Macro: MEMWB_BUS_TIMEOUT_EN.
- Enabled:
  - An 8-bit counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - When it reaches TIMEOUT: drop o_mem_req, return to IDLE, pulse o_mem_exception for one cycle, no writeback.
  - An ack arriving in the same cycle the count reaches TIMEOUT takes priority; it completes normally.
- Disabled: no counter; BUSY waits indefinitely for ack.

Test Plan:
- Non-mem ops, back to back: i_submit=1 for 3 cycles with i_reg_ie=8'h02/04/08, i_data=1/2/3 -> o_reg_ie/o_reg_data show 02/1, 04/2, 08/3 on the three following cycles; o_ready stays 1.
- Word load: i_addr=16'h1234, i_reg_ie=8'h10, ack 3 cycles after req with i_mem_data=16'hBEEF -> o_mem_addr=1234, o_mem_sel=11; o_ready=0 during BUSY; o_reg_ie=10, o_reg_data=BEEF one cycle after ack.
- Byte load, odd address: i_addr=16'h0201, i_mem_data=16'hA55A -> o_mem_addr=0100, o_mem_sel=10, o_reg_data=00A5.
- Byte store: i_addr=16'h0200, i_data=16'h00C3 -> o_mem_we=1, o_mem_sel=01, o_mem_data=C3C3; o_reg_ie stays 0.
- Bus error: load with ack+err -> o_mem_exception=1 for exactly one cycle, no writeback. With MEMWB_BUS_TIMEOUT_EN and TIMEOUT=4, no ack -> req drops and exception pulses after 4 BUSY cycles.
- Reset in BUSY: assert i_rst for one cycle mid-wait, then send an ack -> o_mem_req=0, state IDLE, no writeback, no exception.
